// File: rtl/maple_pkg.sv
// maple_pkg: shared types and helpers for the Maple transaction sequencer.
//   state_e  - sequencer states
//   STAT_*   - status byte codes returned to the host after each transaction
//   hdr_len  - remaining host bytes after the first header byte (3 + 4*N)
package maple_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_HDR,
    ST_TX_DATA,
    ST_TX_CRC,
    ST_TX_DRAIN,
    ST_RX_WAIT,
    ST_RX_DATA,
    ST_STATUS
  } state_e;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_TIMEOUT = 8'h01;
  localparam logic [7:0] STAT_OVF     = 8'h02;
  localparam logic [7:0] STAT_CRC     = 8'h03;

  // First header byte is the word count N; three header bytes plus 4*N data
  // bytes remain. Range 3..1023 fits in 11 bits.
  function automatic logic [10:0] hdr_len(input logic [7:0] n);
    return 11'd3 + {1'b0, n, 2'b00};
  endfunction

endpackage

// File: rtl/maple_txn_ctrl_if.sv
// maple_txn_ctrl_if: host FIFO, transmitter and receiver signals of the
// Maple transaction sequencer.
//   master - the sequencer (drives h_rx_ready, h_tx_*, tx_*, rx_enable)
//   slave  - the surrounding FIFO/transmitter/receiver blocks
interface maple_txn_ctrl_if;
  // host FIFO, host -> controller
  logic       h_rx_valid;
  logic [7:0] h_rx_data;
  logic       h_rx_ready;
  // host FIFO, controller -> host
  logic       h_tx_valid;
  logic [7:0] h_tx_data;
  logic       h_tx_ready;
  logic       h_tx_end;
  // transmitter
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_full;
  logic       tx_busy;
  // receiver
  logic       rx_enable;
  logic       rx_start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_end;

  modport master (
    input  h_rx_valid, h_rx_data, h_tx_ready, tx_full, tx_busy,
           rx_start, rx_valid, rx_data, rx_end,
    output h_rx_ready, h_tx_valid, h_tx_data, h_tx_end,
           tx_wr, tx_data, tx_last, rx_enable
  );

  modport slave (
    output h_rx_valid, h_rx_data, h_tx_ready, tx_full, tx_busy,
           rx_start, rx_valid, rx_data, rx_end,
    input  h_rx_ready, h_tx_valid, h_tx_data, h_tx_end,
           tx_wr, tx_data, tx_last, rx_enable
  );
endinterface

// File: rtl/maple_xor_chk.sv
// maple_xor_chk: 8-bit XOR accumulator used for the Maple check byte.
//   clk, reset - clock, asynchronous active-low reset
//   clr        - restart accumulation (if en is also set, d becomes the value)
//   en, d      - fold byte d into the accumulator
//   acc        - current accumulated XOR
module maple_xor_chk (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] acc
);
  logic [7:0] acc_q, acc_d;

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = en ? d : 8'h00;
    else if (en) acc_d = acc_q ^ d;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= 8'h00;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/maple_txn_ctrl.sv
// maple_txn_ctrl: Maple bus frame-level transaction sequencer.
// Pulls one host frame, streams it to the transmitter with an appended XOR
// check byte, waits for the bus to turn around, forwards the reply to the
// host and closes with a status byte flagged by h_tx_end.
//   clk, reset - clock, asynchronous active-low reset
//   bus        - host FIFO / transmitter / receiver signals (master side)
//   busy       - transaction in progress
// Parameters: RX_TIMEOUT (cycles allowed for the reply start),
//             RX_MAX_BYTES (largest accepted reply).
// Build option: define MAPLE_RX_CRC_CHECK_EN to verify the reply's XOR check
// byte and report STAT_CRC on mismatch.
module maple_txn_ctrl
  import maple_pkg::*;
#(
  parameter int RX_TIMEOUT   = 48000,
  parameter int RX_MAX_BYTES = 1029
) (
  input  logic             clk,
  input  logic             reset,
  maple_txn_ctrl_if.master bus,
  output logic             busy
);
  localparam int TMO_W = $clog2(RX_TIMEOUT + 1);
  localparam int RXC_W = $clog2(RX_MAX_BYTES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(RX_TIMEOUT - 1);
  localparam logic [RXC_W-1:0] RXC_MAX  = RXC_W'(RX_MAX_BYTES);

  state_e           state_q, state_d;
  logic [10:0]      cnt_q, cnt_d;       // host bytes still to forward
  logic [TMO_W-1:0] tmo_q, tmo_d;       // reply start timeout
  logic [RXC_W-1:0] rxc_q, rxc_d;       // reply bytes delivered to host
  logic [7:0]       status_q, status_d;

  logic       rx_ready;
  logic       host_acc;
  logic       rx_full;
  logic       rx_drop;
  logic [7:0] tx_chk;

  assign host_acc = bus.h_rx_valid & rx_ready;
  assign rx_full  = (rxc_q >= RXC_MAX);
  assign rx_drop  = ~bus.h_tx_ready | rx_full;

  // Clearing in IDLE while accepting loads the first header byte directly.
  maple_xor_chk u_tx_chk (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == ST_IDLE),
    .en    (host_acc),
    .d     (bus.h_rx_data),
    .acc   (tx_chk)
  );

`ifdef MAPLE_RX_CRC_CHECK_EN
  logic [7:0] rx_chk;
  logic [7:0] rx_chk_next;

  maple_xor_chk u_rx_chk (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_RX_DATA),
    .en    ((state_q == ST_RX_DATA) & bus.rx_valid),
    .d     (bus.rx_data),
    .acc   (rx_chk)
  );

  // Include a byte arriving together with rx_end.
  assign rx_chk_next = rx_chk ^ (bus.rx_valid ? bus.rx_data : 8'h00);
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      rxc_q    <= '0;
      status_q <= STAT_OK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rxc_q    <= rxc_d;
      status_q <= status_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    rxc_d    = rxc_q;
    status_d = status_q;
    unique case (state_q)
      ST_IDLE: begin
        status_d = STAT_OK;
        if (host_acc) begin
          cnt_d   = hdr_len(bus.h_rx_data);
          state_d = ST_TX_HDR;
        end
      end
      ST_TX_HDR, ST_TX_DATA: begin
        if (host_acc) begin
          cnt_d = cnt_q - 11'd1;
          // Count starts at 3+4N, so the header ends the first time the low
          // two bits return to zero.
          if (cnt_d == 11'd0)
            state_d = ST_TX_CRC;
          else if (state_q == ST_TX_HDR && cnt_d[1:0] == 2'b00)
            state_d = ST_TX_DATA;
        end
      end
      ST_TX_CRC: begin
        if (!bus.tx_full) state_d = ST_TX_DRAIN;
      end
      ST_TX_DRAIN: begin
        if (!bus.tx_busy) begin
          state_d = ST_RX_WAIT;
          tmo_d   = TMO_LOAD;
          rxc_d   = '0;
        end
      end
      ST_RX_WAIT: begin
        tmo_d = tmo_q - TMO_W'(1);
        if (bus.rx_start) begin
          state_d = ST_RX_DATA;
        end else if (tmo_q == '0) begin
          status_d = STAT_TIMEOUT;
          state_d  = ST_STATUS;
        end
      end
      ST_RX_DATA: begin
        if (bus.rx_valid) begin
          if (rx_drop) status_d = STAT_OVF;
          else         rxc_d    = rxc_q + RXC_W'(1);
        end
        if (bus.rx_end) begin
          state_d = ST_STATUS;
`ifdef MAPLE_RX_CRC_CHECK_EN
          if (status_d == STAT_OK && rx_chk_next != 8'h00) status_d = STAT_CRC;
`endif
        end
      end
      ST_STATUS: begin
        if (bus.h_tx_ready) begin
          state_d  = ST_IDLE;
          status_d = STAT_OK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rx_ready       = 1'b0;
    bus.tx_wr      = 1'b0;
    bus.tx_data    = 8'h00;
    bus.tx_last    = 1'b0;
    bus.h_tx_valid = 1'b0;
    bus.h_tx_data  = 8'h00;
    bus.h_tx_end   = 1'b0;
    bus.rx_enable  = 1'b0;
    unique case (state_q)
      // Gating with reset keeps h_rx_ready low while reset is held.
      ST_IDLE:               rx_ready = reset;
      ST_TX_HDR, ST_TX_DATA: rx_ready = ~bus.tx_full;
      ST_TX_CRC: begin
        bus.tx_wr   = ~bus.tx_full;
        bus.tx_last = ~bus.tx_full;
        if (!bus.tx_full) bus.tx_data = tx_chk;
      end
      ST_RX_WAIT: bus.rx_enable = 1'b1;
      ST_RX_DATA: begin
        bus.rx_enable  = 1'b1;
        bus.h_tx_valid = bus.rx_valid & ~rx_full;
        if (bus.rx_valid && !rx_full) bus.h_tx_data = bus.rx_data;
      end
      ST_STATUS: begin
        bus.h_tx_valid = 1'b1;
        bus.h_tx_data  = status_q;
        bus.h_tx_end   = 1'b1;
      end
      default: ;
    endcase
    // Host bytes pass straight through to the transmitter.
    if (host_acc) begin
      bus.tx_wr   = 1'b1;
      bus.tx_data = bus.h_rx_data;
    end
  end

  assign bus.h_rx_ready = rx_ready;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_maple_txn_ctrl.sv
// Directed testbench for maple_txn_ctrl. Uses a short RX_TIMEOUT and a small
// RX_MAX_BYTES so the timeout and reply-limit boundaries are reached quickly.
module tb_maple_txn_ctrl;
  localparam int T    = 40;
  localparam int RMAX = 6;

  logic clk;
  logic reset;
  logic busy;
  int   tests;
  int   fails;

  maple_txn_ctrl_if bus ();

  maple_txn_ctrl #(.RX_TIMEOUT(T), .RX_MAX_BYTES(RMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Transfer logs, sampled on the falling edge.
  logic [7:0] tx_log[$];
  logic       txl_log[$];
  logic [7:0] ht_log[$];
  logic       hte_log[$];

  always @(negedge clk) begin
    if (reset) begin
      if (bus.tx_wr) begin
        tx_log.push_back(bus.tx_data);
        txl_log.push_back(bus.tx_last);
      end
      if (bus.h_tx_valid && bus.h_tx_ready) begin
        ht_log.push_back(bus.h_tx_data);
        hte_log.push_back(bus.h_tx_end);
      end
    end
  end

  logic [7:0] frm[16];
  logic [7:0] rpl[16];
  logic [7:0] exp_b[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    txl_log.delete();
    ht_log.delete();
    hte_log.delete();
  endtask

  // Feed n frame bytes; hold tx_full for stall_cycles when byte stall_at is due.
  task automatic host_send(input int n, input int stall_at, input int stall_cycles);
    int i = 0;
    int guard = 0;
    int stall_left = stall_cycles;
    while (i < n && guard < 200) begin
      bus.h_rx_valid = 1'b1;
      bus.h_rx_data  = frm[i];
      bus.tx_full    = (i == stall_at && stall_left > 0);
      #1;
      if (bus.tx_full) begin
        stall_left--;
        tests++;
        if (bus.tx_wr !== 1'b0) begin
          fails++;
          $display("FAIL stall_no_write: tx_wr=%b want 0 while tx_full", bus.tx_wr);
        end
      end
      if (bus.h_rx_ready) i++;
      step();
      guard++;
    end
    bus.h_rx_valid = 1'b0;
    bus.tx_full    = 1'b0;
    tests++;
    if (i != n) begin
      fails++;
      $display("FAIL host_send: accepted %0d bytes want %0d", i, n);
    end
  endtask

  task automatic wait_rx_enable();
    int guard = 0;
    #1;
    while (!bus.rx_enable && guard < 50) begin
      step();
      #1;
      guard++;
    end
    tests++;
    if (bus.rx_enable !== 1'b1) begin
      fails++;
      $display("FAIL wait_rx_enable: rx_enable=%b want 1 within 50 cycles", bus.rx_enable);
    end
  endtask

  // rx_start, n reply bytes (drop_at gets h_tx_ready=0), then rx_end either
  // with the last byte or on its own cycle. Returns in the status cycle.
  task automatic reply(input int n, input int drop_at, input bit end_with_last);
    bus.rx_start = 1'b1;
    step();
    bus.rx_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.rx_valid   = 1'b1;
      bus.rx_data    = rpl[i];
      bus.h_tx_ready = (i != drop_at);
      bus.rx_end     = end_with_last && (i == n - 1);
      step();
    end
    bus.rx_valid   = 1'b0;
    bus.h_tx_ready = 1'b1;
    bus.rx_end     = 1'b0;
    if (!end_with_last || n == 0) begin
      bus.rx_end = 1'b1;
      step();
      bus.rx_end = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.h_rx_valid = 1'b1;
    bus.h_rx_data  = 8'h5A;
    #1;
    tests++;
    if (bus.h_rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_rx_ready: got %b want 0", bus.h_rx_ready);
    end
    tests++;
    if ({bus.tx_wr, bus.tx_data, busy} !== 10'd0) begin
      fails++;
      $display("FAIL reset_tx_quiet: tx_wr=%b tx_data=%h busy=%b want all 0",
               bus.tx_wr, bus.tx_data, busy);
    end
    bus.h_rx_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    tests++;
    if ({bus.h_rx_ready, busy, bus.tx_wr, bus.h_tx_valid, bus.rx_enable} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_release: rdy/busy/wr/htv/rxen=%b want 10000",
               {bus.h_rx_ready, busy, bus.tx_wr, bus.h_tx_valid, bus.rx_enable});
    end
    step();
  endtask

  task automatic test_basic_n0();
    clear_logs();
    frm[0] = 8'h00; frm[1] = 8'h11; frm[2] = 8'h22; frm[3] = 8'h33;
    bus.tx_busy = 1'b1;
    host_send(4, -1, 0);
    step(); step(); step();
    tests++;
    if (bus.rx_enable !== 1'b0) begin
      fails++;
      $display("FAIL drain_wait: rx_enable=%b want 0 while tx_busy", bus.rx_enable);
    end
    bus.tx_busy = 1'b0;
    exp_b[0] = 8'h00; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33; exp_b[4] = 8'h00;
    tests++;
    if (tx_log.size() != 5) begin
      fails++;
      $display("FAIL basic_tx_count: got %0d want 5", tx_log.size());
    end
    for (int i = 0; i < 5 && i < tx_log.size(); i++) begin
      tests++;
      if ({txl_log[i], tx_log[i]} !== {(i == 4), exp_b[i]}) begin
        fails++;
        $display("FAIL basic_tx[%0d]: last/data=%b/%h want %b/%h",
                 i, txl_log[i], tx_log[i], (i == 4), exp_b[i]);
      end
    end
    wait_rx_enable();
    rpl[0] = 8'h12; rpl[1] = 8'h34; rpl[2] = 8'h56; rpl[3] = 8'h70;
    reply(4, -1, 1'b0);
    step();
    exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56; exp_b[3] = 8'h70; exp_b[4] = 8'h00;
    tests++;
    if (ht_log.size() != 5) begin
      fails++;
      $display("FAIL basic_host_count: got %0d want 5", ht_log.size());
    end
    for (int i = 0; i < 5 && i < ht_log.size(); i++) begin
      tests++;
      if ({hte_log[i], ht_log[i]} !== {(i == 4), exp_b[i]}) begin
        fails++;
        $display("FAIL basic_host[%0d]: end/data=%b/%h want %b/%h",
                 i, hte_log[i], ht_log[i], (i == 4), exp_b[i]);
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_tx_full_stall();
    clear_logs();
    frm[0] = 8'h01; frm[1] = 8'hAA; frm[2] = 8'hBB; frm[3] = 8'hCC;
    frm[4] = 8'h10; frm[5] = 8'h20; frm[6] = 8'h30; frm[7] = 8'h40;
    host_send(8, 3, 10);
    wait_rx_enable();
    for (int i = 0; i < 8; i++) exp_b[i] = frm[i];
    exp_b[8] = 8'h9C;
    tests++;
    if (tx_log.size() != 9) begin
      fails++;
      $display("FAIL stall_tx_count: got %0d want 9", tx_log.size());
    end
    for (int i = 0; i < 9 && i < tx_log.size(); i++) begin
      tests++;
      if ({txl_log[i], tx_log[i]} !== {(i == 8), exp_b[i]}) begin
        fails++;
        $display("FAIL stall_tx[%0d]: last/data=%b/%h want %b/%h",
                 i, txl_log[i], tx_log[i], (i == 8), exp_b[i]);
      end
    end
    reply(0, -1, 1'b0);
    #1;
    tests++;
    if ({bus.h_tx_valid, bus.h_tx_end, bus.h_tx_data} !== {2'b11, 8'h00}) begin
      fails++;
      $display("FAIL stall_status: v/e/data=%b/%b/%h want 1/1/00",
               bus.h_tx_valid, bus.h_tx_end, bus.h_tx_data);
    end
    step();
  endtask

  task automatic short_frame();
    frm[0] = 8'h00; frm[1] = 8'h01; frm[2] = 8'h02; frm[3] = 8'h03;
    host_send(4, -1, 0);
    wait_rx_enable();
  endtask

  task automatic test_timeout();
    int k;
    clear_logs();
    short_frame();
    // Stray rx_valid / rx_end while waiting for the start must be ignored.
    for (k = 0; k < 3 * T; k++) begin
      bus.rx_valid = (k == 5);
      bus.rx_data  = 8'hEE;
      bus.rx_end   = (k == 6);
      #1;
      if (bus.h_tx_valid) break;
      step();
    end
    bus.rx_valid = 1'b0;
    bus.rx_end   = 1'b0;
    tests++;
    if (k != T) begin
      fails++;
      $display("FAIL timeout_cycle: status at cycle %0d want %0d", k, T);
    end
    tests++;
    if ({bus.h_tx_end, bus.h_tx_data} !== {1'b1, 8'h01}) begin
      fails++;
      $display("FAIL timeout_status: end/data=%b/%h want 1/01", bus.h_tx_end, bus.h_tx_data);
    end
    step();
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_start_at_expiry();
    clear_logs();
    short_frame();
    for (int k = 0; k < T; k++) begin
      bus.rx_start = (k == T - 1);
      step();
    end
    bus.rx_start = 1'b0;
    #1;
    tests++;
    if ({bus.h_tx_valid, bus.rx_enable} !== 2'b01) begin
      fails++;
      $display("FAIL expiry_start: h_tx_valid/rx_enable=%b%b want 01",
               bus.h_tx_valid, bus.rx_enable);
    end
    bus.rx_end = 1'b1;
    step();
    bus.rx_end = 1'b0;
    #1;
    tests++;
    if ({bus.h_tx_valid, bus.h_tx_end, bus.h_tx_data} !== {2'b11, 8'h00}) begin
      fails++;
      $display("FAIL expiry_status: v/e/data=%b/%b/%h want 1/1/00",
               bus.h_tx_valid, bus.h_tx_end, bus.h_tx_data);
    end
    step();
  endtask

  task automatic test_overflow_ready();
    clear_logs();
    short_frame();
    ht_log.delete();
    hte_log.delete();
    rpl[0] = 8'h12; rpl[1] = 8'h34; rpl[2] = 8'h56; rpl[3] = 8'h70;
    reply(4, 1, 1'b0);
    step();
    exp_b[0] = 8'h12; exp_b[1] = 8'h56; exp_b[2] = 8'h70; exp_b[3] = 8'h02;
    tests++;
    if (ht_log.size() != 4) begin
      fails++;
      $display("FAIL ovf_count: got %0d want 4", ht_log.size());
    end
    for (int i = 0; i < 4 && i < ht_log.size(); i++) begin
      tests++;
      if ({hte_log[i], ht_log[i]} !== {(i == 3), exp_b[i]}) begin
        fails++;
        $display("FAIL ovf_host[%0d]: end/data=%b/%h want %b/%h",
                 i, hte_log[i], ht_log[i], (i == 3), exp_b[i]);
      end
    end
  endtask

  task automatic test_max_bytes();
    clear_logs();
    short_frame();
    for (int i = 0; i < 8; i++) rpl[i] = 8'(i + 1);
    reply(8, -1, 1'b0);
    step();
    for (int i = 0; i < RMAX; i++) exp_b[i] = 8'(i + 1);
    exp_b[RMAX] = 8'h02;
    tests++;
    if (ht_log.size() != RMAX + 1) begin
      fails++;
      $display("FAIL max_count: got %0d want %0d", ht_log.size(), RMAX + 1);
    end
    for (int i = 0; i <= RMAX && i < ht_log.size(); i++) begin
      tests++;
      if ({hte_log[i], ht_log[i]} !== {(i == RMAX), exp_b[i]}) begin
        fails++;
        $display("FAIL max_host[%0d]: end/data=%b/%h want %b/%h",
                 i, hte_log[i], ht_log[i], (i == RMAX), exp_b[i]);
      end
    end
  endtask

  task automatic test_rx_check();
    logic [7:0] want;
    clear_logs();
    short_frame();
    rpl[0] = 8'h12; rpl[1] = 8'h34; rpl[2] = 8'h56; rpl[3] = 8'h71;
    // Check byte arrives together with rx_end.
    reply(4, -1, 1'b1);
    step();
`ifdef MAPLE_RX_CRC_CHECK_EN
    want = 8'h03;
`else
    want = 8'h00;
`endif
    tests++;
    if (ht_log.size() != 5) begin
      fails++;
      $display("FAIL chk_count: got %0d want 5", ht_log.size());
    end
    tests++;
    if (ht_log.size() == 5 && {ht_log[3], ht_log[4], hte_log[4]} !== {8'h71, want, 1'b1}) begin
      fails++;
      $display("FAIL chk_status: last/status/end=%h/%h/%b want 71/%h/1",
               ht_log[3], ht_log[4], hte_log[4], want);
    end
  endtask

  task automatic test_reset_in_rx();
    clear_logs();
    short_frame();
    bus.rx_start = 1'b1;
    step();
    bus.rx_start = 1'b0;
    rpl[0] = 8'hA5;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    step();
    bus.rx_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.tx_wr, bus.tx_last, bus.tx_data, bus.h_tx_valid, bus.h_tx_end, bus.h_tx_data,
         bus.rx_enable, bus.h_rx_ready, busy} !== 23'd0) begin
      fails++;
      $display("FAIL abort_outputs: rxen=%b htv=%b rdy=%b busy=%b want all 0",
               bus.rx_enable, bus.h_tx_valid, bus.h_rx_ready, busy);
    end
    clear_logs();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #1;
    tests++;
    if ({bus.h_rx_ready, busy, bus.rx_enable} !== 3'b100) begin
      fails++;
      $display("FAIL abort_idle: rdy/busy/rxen=%b want 100",
               {bus.h_rx_ready, busy, bus.rx_enable});
    end
    tests++;
    if (ht_log.size() != 0) begin
      fails++;
      $display("FAIL abort_no_status: host bytes=%0d want 0", ht_log.size());
    end
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset          = 1'b0;
    bus.h_rx_valid = 1'b0;
    bus.h_rx_data  = 8'h00;
    bus.h_tx_ready = 1'b1;
    bus.tx_full    = 1'b0;
    bus.tx_busy    = 1'b0;
    bus.rx_start   = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.rx_end     = 1'b0;
    step();
    test_reset();
    test_basic_n0();
    test_tx_full_stall();
    test_timeout();
    test_start_at_expiry();
    test_overflow_ready();
    test_max_bytes();
    test_rx_check();
    test_reset_in_rx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
